// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared arbiter state encoding and width helper
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // ceil(log2(n)) with a floor of one bit so single-bit selects stay legal
    function automatic int myclog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_wr_arbiter_rr_pick: combinational round-robin pick of the first request at or after a pointer
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = myclog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   idx_o,
    output logic            hit_o
);

    logic [PW-1:0] hi_idx;
    logic [PW-1:0] lo_idx;
    logic          hi_hit;

    // lowest request at or above the pointer wins; otherwise wrap to the lowest request overall
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_hit = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) lo_idx = PW'(i);
            if (req_i[i] && PW'(i) >= ptr_i) begin
                hi_idx = PW'(i);
                hi_hit = 1'b1;
            end
        end
    end

    assign idx_o = hi_hit ? hi_idx : lo_idx;
    assign hit_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet arbiter sharing one FIFO write port, with forced release
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int DW        = 64,
    parameter  int MAX_BURST = 16,
    parameter  int BCNT_W    = 5,
    localparam int GW        = myclog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               fifo_w_req,
    output logic [DW-1:0]      fifo_data,
    input  logic               fifo_full,
    output logic [GW-1:0]      grant_id,
    output logic               busy,
    output logic               trunc
);

    arb_state_e        state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [BCNT_W-1:0] beat_q, beat_d;
    logic              trunc_q, trunc_d;
    logic [GW-1:0]     pick_idx;
    logic              pick_hit;
    logic [GW-1:0]     next_ptr;
    logic              xfer;
    logic              wr;
    logic              burst_end;
    logic [DW-1:0]     words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = req_data[g*DW +: DW];
    end

    fifo_wr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (GW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .hit_o (pick_hit)
    );

    assign xfer       = state_q == XFER;
    assign wr         = xfer & req_valid[grant_q] & ~fifo_full;
    assign next_ptr   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
    assign burst_end  = (beat_q + 1'b1) == BCNT_W'(MAX_BURST);
    assign req_ready  = (xfer & ~fifo_full) ? (NREQ'(1) << grant_q) : '0;
    assign fifo_w_req = wr;
    assign fifo_data  = xfer ? words[grant_q] : '0;
    assign grant_id   = grant_q;
    assign busy       = xfer;
    assign trunc      = trunc_q;

    // arbitrate in IDLE; in XFER count accepted beats and release on last or at the burst limit
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        trunc_d  = 1'b0;
        case (state_q)
            IDLE: if (pick_hit) begin
                grant_d = pick_idx;
                beat_d  = '0;
                state_d = XFER;
            end
            XFER: if (wr) begin
                beat_d = beat_q + 1'b1;
                if (req_last[grant_q] || burst_end) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                    trunc_d  = ~req_last[grant_q];
                end
            end
        endcase
    end

    // state, pointer, grant and beat registers; reset abandons any packet in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            beat_q   <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            beat_q   <= beat_d;
            trunc_q  <= trunc_d;
        end
    end

endmodule
